// File: rtl/key_event_arbiter_if.sv
// Key-event bus between the button front-ends, the arbiter and the vending control FSM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface key_event_arbiter_if #(
   parameter int unsigned N_KEYS = 4,
   parameter int unsigned IDX_W  = 2
);
   logic              enable;
   logic [N_KEYS-1:0] key_pulse;
   logic              evt_valid;
   logic              evt_ready;
   logic [IDX_W-1:0]  evt_key;
   logic [N_KEYS-1:0] pending;
   logic              drop_flag;
   logic              drop_clr;

   modport master (
      output enable, key_pulse, evt_ready, drop_clr,
      input  evt_valid, evt_key, pending, drop_flag
   );

   modport slave (
      input  enable, key_pulse, evt_ready, drop_clr,
      output evt_valid, evt_key, pending, drop_flag
   );
endinterface

// File: rtl/key_event_arbiter.sv
// Latches key pulses as pending requests and serialises them into a valid/ready key-index stream.
// Round-robin by default; define KEY_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module key_event_arbiter #(
   parameter int unsigned N_KEYS = 4,
   parameter int unsigned IDX_W  = 2
) (
   input logic               i_clk,
   input logic               i_rst_n,
   key_event_arbiter_if.slave io_bus
);

   typedef enum logic [0:0] {StIdle, StPresent} state_t;

   state_t            r_state, w_state_d;
   logic [N_KEYS-1:0] r_pending, w_pending_d;
   logic [N_KEYS-1:0] w_clr_mask, w_drop;
   logic [IDX_W-1:0]  r_evt_key, w_evt_key_d;
   logic [IDX_W-1:0]  w_winner;
   logic              w_found;
   logic              w_grant;
   logic              r_drop_flag, w_drop_flag_d;
`ifndef KEY_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]  r_last_grant, w_last_grant_d;
`endif

   // Winner selection over the currently pending set
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
`ifdef KEY_ARB_FIXED_PRIO_EN
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_winner = IDX_W'(i);
            w_found  = 1'b1;
         end
      end
`else
      for (int k = 1; k <= int'(N_KEYS); k++) begin
         int               idx;
         logic [IDX_W-1:0] sel;
         idx = int'(r_last_grant) + k;
         if (idx >= int'(N_KEYS)) idx = idx - int'(N_KEYS);
         sel = IDX_W'(idx);
         if (!w_found && r_pending[sel]) begin
            w_winner = sel;
            w_found  = 1'b1;
         end
      end
`endif
   end

   // Capture and drop detection; a same-cycle set beats the grant-clear
   always_comb begin
      w_grant    = (r_state == StIdle) && io_bus.enable && w_found;
      w_clr_mask = '0;
      if (w_grant) w_clr_mask[w_winner] = 1'b1;
      w_drop        = io_bus.key_pulse & r_pending & ~w_clr_mask;
      w_pending_d   = (r_pending & ~w_clr_mask) | io_bus.key_pulse;
      w_drop_flag_d = (|w_drop) | (r_drop_flag & ~io_bus.drop_clr);
   end

   always_comb begin
      w_state_d   = r_state;
      w_evt_key_d = r_evt_key;
`ifndef KEY_ARB_FIXED_PRIO_EN
      w_last_grant_d = r_last_grant;
`endif
      case (r_state)
         StIdle: begin
            if (w_grant) begin
               w_state_d   = StPresent;
               w_evt_key_d = w_winner;
            end
         end
         StPresent: begin
            if (io_bus.evt_ready) begin
               w_state_d = StIdle;
`ifndef KEY_ARB_FIXED_PRIO_EN
               w_last_grant_d = r_evt_key;
`endif
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_pending   <= '0;
         r_evt_key   <= '0;
         r_drop_flag <= 1'b0;
`ifndef KEY_ARB_FIXED_PRIO_EN
         r_last_grant <= IDX_W'(N_KEYS - 1);
`endif
      end else begin
         r_state     <= w_state_d;
         r_pending   <= w_pending_d;
         r_evt_key   <= w_evt_key_d;
         r_drop_flag <= w_drop_flag_d;
`ifndef KEY_ARB_FIXED_PRIO_EN
         r_last_grant <= w_last_grant_d;
`endif
      end
   end

   assign io_bus.evt_valid = (r_state == StPresent);
   assign io_bus.evt_key   = r_evt_key;
   assign io_bus.pending   = r_pending;
   assign io_bus.drop_flag = r_drop_flag;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: capture, round-robin order, stall, drops, enable, reset.
module tb_key_event_arbiter;
   localparam int unsigned N_KEYS = 4;
   localparam int unsigned IDX_W  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   key_event_arbiter_if #(.N_KEYS(N_KEYS), .IDX_W(IDX_W)) bus ();

   key_event_arbiter #(.N_KEYS(N_KEYS), .IDX_W(IDX_W)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input logic [N_KEYS-1:0] k);
      bus.key_pulse = k;
      tick();
      bus.key_pulse = '0;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [IDX_W-1:0] k,
                          input logic [N_KEYS-1:0] p);
      chk({tag, ".valid"}, 32'(bus.evt_valid), 32'(v));
      if (v) chk({tag, ".key"}, 32'(bus.evt_key), 32'(k));
      chk({tag, ".pending"}, 32'(bus.pending), 32'(p));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable    = 1'b1;
      bus.key_pulse = '0;
      bus.evt_ready = 1'b1;
      bus.drop_clr  = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, 2'd0, 4'b0000);
      chk("reset.key", 32'(bus.evt_key), 32'd0);
      chk("reset.drop", 32'(bus.drop_flag), 32'd0);
      rst_n = 1'b1;

      // Single press, latency and accept
      pulse_tick(4'b0100);
      chk_out("t1.cap", 1'b0, 2'd0, 4'b0100);
      tick();
      chk_out("t1.grant", 1'b1, 2'd2, 4'b0000);
      tick();
      chk_out("t1.acc", 1'b0, 2'd0, 4'b0000);

      // Fresh pointer: 0,1,3 then 0,3 after wrap
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pulse_tick(4'b1011);
      chk_out("t2.cap", 1'b0, 2'd0, 4'b1011);
      tick(); chk_out("t2.g0", 1'b1, 2'd0, 4'b1010);
      tick(); chk_out("t2.a0", 1'b0, 2'd0, 4'b1010);
      tick(); chk_out("t2.g1", 1'b1, 2'd1, 4'b1000);
      tick(); chk_out("t2.a1", 1'b0, 2'd0, 4'b1000);
      tick(); chk_out("t2.g3", 1'b1, 2'd3, 4'b0000);
      tick(); chk_out("t2.a3", 1'b0, 2'd0, 4'b0000);
      pulse_tick(4'b1001);
      chk_out("t2.cap2", 1'b0, 2'd0, 4'b1001);
      tick(); chk_out("t2.wrap0", 1'b1, 2'd0, 4'b1000);
      tick(); chk_out("t2.wa0", 1'b0, 2'd0, 4'b1000);
      tick(); chk_out("t2.wrap3", 1'b1, 2'd3, 4'b0000);
      tick(); chk_out("t2.wa3", 1'b0, 2'd0, 4'b0000);

      // Stall with key 1 presented, re-press, then drop
      bus.evt_ready = 1'b0;
      pulse_tick(4'b0010);
      chk_out("t3.cap", 1'b0, 2'd0, 4'b0010);
      tick(); chk_out("t3.grant", 1'b1, 2'd1, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tick(); chk_out("t3.stallA", 1'b1, 2'd1, 4'b0000);
      end
      pulse_tick(4'b0010);
      chk_out("t3.repress", 1'b1, 2'd1, 4'b0010);
      chk("t3.nodrop", 32'(bus.drop_flag), 32'd0);
      pulse_tick(4'b0010);
      chk_out("t3.third", 1'b1, 2'd1, 4'b0010);
      chk("t3.drop", 32'(bus.drop_flag), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick(); chk_out("t3.stallB", 1'b1, 2'd1, 4'b0010);
      end
      bus.evt_ready = 1'b1;
      tick(); chk_out("t3.acc", 1'b0, 2'd0, 4'b0010);
      tick(); chk_out("t3.grant2", 1'b1, 2'd1, 4'b0000);
      tick(); chk_out("t3.acc2", 1'b0, 2'd0, 4'b0000);

      // Drop-clear races with a new drop
      bus.enable = 1'b0;
      pulse_tick(4'b0100);
      chk("t5.held", 32'(bus.drop_flag), 32'd1);
      bus.drop_clr = 1'b1;
      pulse_tick(4'b0100);
      chk("t5.race", 32'(bus.drop_flag), 32'd1);
      tick();
      chk("t5.clr", 32'(bus.drop_flag), 32'd0);
      bus.drop_clr = 1'b0;
      chk_out("t5.idle", 1'b0, 2'd0, 4'b0100);

      // Enable gating with a fresh pointer
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pulse_tick(4'b0101);
      chk_out("t4.cap", 1'b0, 2'd0, 4'b0101);
      tick(); chk_out("t4.gated", 1'b0, 2'd0, 4'b0101);
      bus.enable = 1'b1;
      tick(); chk_out("t4.g0", 1'b1, 2'd0, 4'b0100);
      tick(); chk_out("t4.a0", 1'b0, 2'd0, 4'b0100);
      tick(); chk_out("t4.g2", 1'b1, 2'd2, 4'b0000);
      tick(); chk_out("t4.a2", 1'b0, 2'd0, 4'b0000);

      // Reset while presenting discards event and pending
      bus.evt_ready = 1'b0;
      pulse_tick(4'b1000);
      tick(); chk_out("t6.g3", 1'b1, 2'd3, 4'b0000);
      pulse_tick(4'b0011);
      chk_out("t6.pend", 1'b1, 2'd3, 4'b0011);
      rst_n = 1'b0;
      tick();
      chk_out("t6.rst", 1'b0, 2'd0, 4'b0000);
      chk("t6.rstkey", 32'(bus.evt_key), 32'd0);
      rst_n = 1'b1;
      bus.evt_ready = 1'b1;
      pulse_tick(4'b1000);
      chk_out("t6.cap", 1'b0, 2'd0, 4'b1000);
      tick(); chk_out("t6.g3b", 1'b1, 2'd3, 4'b0000);
      tick(); chk_out("t6.a3b", 1'b0, 2'd0, 4'b0000);

      // Same-cycle set beats grant-clear, and is not a drop
      bus.enable = 1'b0;
      pulse_tick(4'b0010);
      bus.enable = 1'b1;
      pulse_tick(4'b0010);
      chk_out("t7.setwin", 1'b1, 2'd1, 4'b0010);
      chk("t7.nodrop", 32'(bus.drop_flag), 32'd0);
      tick(); chk_out("t7.acc", 1'b0, 2'd0, 4'b0010);
      tick(); chk_out("t7.g1", 1'b1, 2'd1, 4'b0000);
      tick(); chk_out("t7.a1", 1'b0, 2'd0, 4'b0000);

`ifdef KEY_ARB_FIXED_PRIO_EN
      pulse_tick(4'b0110);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("fp.g1", 1'b1, 2'd1, 4'b0100);
         pulse_tick(4'b0010);
         chk_out("fp.acc", 1'b0, 2'd0, 4'b0110);
      end
      tick(); chk_out("fp.g1last", 1'b1, 2'd1, 4'b0100);
      tick(); tick(); chk_out("fp.g2", 1'b1, 2'd2, 4'b0000);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Collects one-cycle key pulses from the per-button debounce/edge-detect blocks and latches each as a pending request.
- Serialises pending requests into a single key-index event stream for the vending control FSM, using a valid/ready handshake.
- Shares the FSM's single command input fairly between buttons (round-robin) and flags any presses lost because the key was already pending.

Parameters:
- N_KEYS, 4, number of key pulse inputs (2..16).
- IDX_W, 2, width of the key index; must equal ceil(log2(N_KEYS)).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- enable  input  1  1 = grants allowed; 0 = capture pulses but issue no new grants.
- key_pulse  input  N_KEYS  one-cycle press pulses; bit i = key i.
- evt_valid  output  1  event available on evt_key.
- evt_ready  input  1  consumer accepts the event when evt_valid=1.
- evt_key  output  IDX_W  index of the granted key.
- pending  output  N_KEYS  pending request register, for status/debug.
- drop_flag  output  1  sticky; a pulse arrived for a key already pending.
- drop_clr  input  1  clears drop_flag.

Behaviour:
Reset (rst_n=0 at posedge):
- evt_valid=0, evt_key=0, pending=0, drop_flag=0.
- last_grant=N_KEYS-1, so key 0 has first priority; state=IDLE.
- Reset mid-handshake discards the presented event and all pending requests.

Capture:
- key_pulse[i]=1 sets pending[i] at the next edge.
- Set wins over a same-cycle grant-clear of the same bit: that bit stays 1.
- key_pulse[i]=1 while pending[i] is already 1 (and not being cleared this cycle) sets drop_flag.
- drop_flag clears on drop_clr=1; a new drop in the same cycle wins (flag stays 1).
- Multiple pulse bits may be set in one cycle; all are captured.

FSM:
- IDLE: if enable=1 and pending!=0, select a key by round-robin, then at the same edge:
  - evt_key <= winner, evt_valid <= 1, pending[winner] <= 0 (unless a set wins), go to PRESENT.
  - Otherwise stay in IDLE with evt_valid=0.
- PRESENT: evt_valid=1, and evt_key is held stable until accepted.
  - On evt_valid & evt_ready: evt_valid <= 0, last_grant <= evt_key, go to IDLE.
  - evt_ready while IDLE is ignored.
  - enable=0 does not withdraw an event that is already presented.

Round-robin:
- Search indices last_grant+1, last_grant+2, ... modulo N_KEYS; the first pending bit found wins.
- Wrap from N_KEYS-1 to 0.

Latency and throughput:
- Pulse at edge t -> pending at t+1 -> evt_valid=1 at t+2 (FSM IDLE, enable=1).
- Maximum throughput is one event per 2 cycles: one IDLE cycle between accepted events.

Widths:
- last_grant and evt_key are IDX_W bits; modulo arithmetic is over N_KEYS, not 2^IDX_W.

Optional Feature:
KEY_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest pending index always wins, and last_grant is unused.
- Not defined: round-robin as above.
- All other behaviour (capture, drop, handshake, latency) is identical in both builds.

Test Plan:
1. Reset, then pulse key 2 with evt_ready=1 -> pending=4'b0100 at t+1; evt_valid=1 with evt_key=2 at t+2; accepted; evt_valid=0 at t+3; pending=0.
2. Same-cycle pulses on keys 0, 1, 3 with ready held 1 -> events 0, 1, 3 in order, 2 cycles apart. Then pulse keys 0 and 3 -> 0 then 3 (search starts after last_grant=3; wraps to 0 first).
3. evt_ready=0 for 10 cycles with key 1 presented -> evt_valid stays 1 and evt_key stays 1. Pulse key 1 again during the stall -> pending[1]=1, no drop. Pulse key 1 a third time -> drop_flag=1. Release ready -> second key 1 event follows.
4. enable=0 and pulse keys 0 and 2 -> pending=4'b0101, evt_valid=0. Set enable=1 -> key 0 event, then key 2 event.
5. drop_flag=1, then assert drop_clr in the same cycle as a new drop -> flag stays 1. Next cycle drop_clr alone -> flag=0.
6. Reset asserted while PRESENT with evt_key=3 and pending=4'b0011 -> next edge: evt_valid=0, pending=0. After release, pulse key 3 -> key 3 is granted (RR pointer back at N_KEYS-1 gives key 0 first, none pending). With KEY_ARB_FIXED_PRIO_EN: pulse keys 1 and 2 repeatedly -> key 1 always wins.
